conv_pool_sched: RTL and testbench

- Sequencer and owner of the shared layer-memory port for the CONV datapath.
- Phase 1: accepts the stream of convolution+ReLU results over a valid/ready handshake and writes each result to layer 0.
- Phase 2: after the full map is in layer 0, runs 2x2 stride-2 max-pooling by reading layer 0 and writing layer 1.
- It is the only block driving crd/cwr/csel, so the convolution engine never touches memory directly.

---
 rtl/conv_pool_sched.sv | 180 ++++++++++++++++++
 tb/tb_conv_pool_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_sched.sv
// Scheduler that owns the layer-memory port: it writes the conv/ReLU results to layer 0,
// then runs 2x2 stride-2 max-pooling from layer 0 into layer 1. All outputs are registered.
module conv_pool_sched #(
  parameter int unsigned IMG_LOG2 = 6,
  parameter int unsigned DATA_W   = 20,
  parameter logic [2:0]  L0_SEL   = 3'b001,
  parameter logic [2:0]  L1_SEL   = 3'b011
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  input  logic                    cv_valid,
  input  logic [2*IMG_LOG2-1:0]   cv_addr,
  input  logic [DATA_W-1:0]       cv_data,
  output logic                    cv_ready,
  output logic                    cwr,
  output logic [2*IMG_LOG2-1:0]   caddr_wr,
  output logic [DATA_W-1:0]       cdata_wr,
  output logic                    crd,
  output logic [2*IMG_LOG2-1:0]   caddr_rd,
  input  logic [DATA_W-1:0]       cdata_rd,
  output logic [2:0]              csel,
  output logic                    done
);

  localparam int unsigned ADDR_W = 2 * IMG_LOG2;
  localparam int unsigned POOL_W = ADDR_W - 2;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] FRAME_LAST = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {StIdle, StL0, StPRd, StPLast, StPWr, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POOL_W-1:0]   p_q, p_d;
  logic [1:0]          k_q, k_d;
  logic [DATA_W-1:0]   max_q, max_next;

  logic                busy_d, cv_ready_d, cwr_d, crd_d, done_d;
  logic [ADDR_W-1:0]   caddr_wr_d, caddr_rd_d;
  logic [DATA_W-1:0]   cdata_wr_d;
  logic [2:0]          csel_d;

  logic                xfer, rd_word_vld, rd_first, word_gt;

  // Read data lags crd by one cycle: words arrive in P_RD k=1..3 and in P_LAST.
  always_comb begin
    xfer        = (state_q == StL0) && cv_valid && cv_ready;
    rd_word_vld = ((state_q == StPRd) && (k_q != 2'd0)) || (state_q == StPLast);
    rd_first    = (state_q == StPRd) && (k_q == 2'd1);
    word_gt     = $signed(cdata_rd) > $signed(max_q);
    max_next    = max_q;
    if (rd_word_vld && (rd_first || word_gt)) begin
      max_next = cdata_rd;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    k_d        = k_q;
    busy_d     = busy;
    cv_ready_d = 1'b0;
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    csel_d     = 3'b000;
    done_d     = 1'b0;
    caddr_wr_d = caddr_wr;
    cdata_wr_d = cdata_wr;
    caddr_rd_d = caddr_rd;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StL0;
          busy_d     = 1'b1;
          cv_ready_d = 1'b1;
          cnt_d      = '0;
          p_d        = '0;
          k_d        = 2'd0;
        end
      end
      StL0: begin
        if (cnt_q == FRAME) begin
          // Final layer-0 write is on the port this cycle; pooling starts next.
          state_d = StPRd;
          p_d     = '0;
          k_d     = 2'd0;
          crd_d   = 1'b1;
          csel_d  = L0_SEL;
        end else begin
          cv_ready_d = !(xfer && (cnt_q == FRAME_LAST));
          if (xfer) begin
            cnt_d      = cnt_q + 1'b1;
            cwr_d      = 1'b1;
            csel_d     = L0_SEL;
            caddr_wr_d = cv_addr;
            cdata_wr_d = cv_data;
          end
        end
      end
      StPRd: begin
        if (k_q == 2'd3) begin
          state_d = StPLast;
        end else begin
          k_d    = k_q + 2'd1;
          crd_d  = 1'b1;
          csel_d = L0_SEL;
        end
      end
      StPLast: begin
        state_d    = StPWr;
        cwr_d      = 1'b1;
        csel_d     = L1_SEL;
        caddr_wr_d = {{(ADDR_W-POOL_W){1'b0}}, p_q};
        cdata_wr_d = max_next;
      end
      StPWr: begin
        if (p_q == {POOL_W{1'b1}}) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StPRd;
          p_d     = p_q + 1'b1;
          k_d     = 2'd0;
          crd_d   = 1'b1;
          csel_d  = L0_SEL;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Window word k sits at {row 2r + k[1], col 2c + k[0]}.
    if (crd_d) begin
      caddr_rd_d = {p_d[POOL_W-1:IMG_LOG2-1], k_d[1], p_d[IMG_LOG2-2:0], k_d[0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      p_q      <= '0;
      k_q      <= 2'd0;
      max_q    <= '0;
      busy     <= 1'b0;
      cv_ready <= 1'b0;
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= 3'b000;
      done     <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      caddr_rd <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      k_q      <= k_d;
      max_q    <= max_next;
      busy     <= busy_d;
      cv_ready <= cv_ready_d;
      cwr      <= cwr_d;
      crd      <= crd_d;
      csel     <= csel_d;
      done     <= done_d;
      caddr_wr <= caddr_wr_d;
      cdata_wr <= cdata_wr_d;
      caddr_rd <= caddr_rd_d;
    end
  end

endmodule

// File: tb/tb_conv_pool_sched.sv
// Bench for conv_pool_sched: models both layer memories, drives frames and compares the
// pooled layer against a window-max reference computed from the data it sent.
module tb_conv_pool_sched;

  localparam int N0 = 4096;
  localparam int N1 = 1024;

  logic        clk = 1'b0;
  logic        reset, start, busy, cv_valid, cv_ready, cwr, crd, done;
  logic [11:0] cv_addr, caddr_wr, caddr_rd;
  logic [19:0] cv_data, cdata_wr;
  logic [19:0] cdata_rd = '0;
  logic [2:0]  csel;

  always #5 clk = ~clk;

  conv_pool_sched dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .cv_valid(cv_valid), .cv_addr(cv_addr), .cv_data(cv_data), .cv_ready(cv_ready),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel), .done(done)
  );

  logic [19:0] mem0 [N0];
  logic [19:0] mem1 [N1];
  logic [19:0] exp0 [N0];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Layer-0 memory: data returned in the cycle after crd.
  always @(posedge clk) if (crd) cdata_rd <= mem0[caddr_rd];

  int l0_wr = 0, l1_wr = 0, done_cnt = 0;
  int lat_err = 0, excl_err = 0, sel_err = 0, idle_err = 0, rdy_err = 0, early_err = 0;
  int fr_xfer = 0, last_xfer_cyc = 0, first_crd_cyc = 0, done_cyc = 0, last_l1_cyc = 0;
  bit crd_seen = 0, pend = 0;
  logic [11:0] pend_addr = '0, last_l1_addr = '0;
  logic [19:0] pend_data = '0;
  logic [11:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;

  always @(negedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (start && !busy) begin
        fr_xfer  <= 0;
        crd_seen <= 1'b0;
      end
      if (crd && cwr) excl_err <= excl_err + 1;
      if ((csel != 3'b000 && !crd && !cwr) || (crd && csel != 3'b001) ||
          (cwr && csel != 3'b001 && csel != 3'b011)) sel_err <= sel_err + 1;
      if ((crd || cwr) && !busy) idle_err <= idle_err + 1;
      if (cv_ready && (crd || (cwr && csel == 3'b011))) rdy_err <= rdy_err + 1;
      if (cwr && csel == 3'b001) begin
        l0_wr <= l0_wr + 1;
        mem0[caddr_wr] <= cdata_wr;
        if (!pend || caddr_wr != pend_addr || cdata_wr != pend_data) lat_err <= lat_err + 1;
      end else if (pend) begin
        lat_err <= lat_err + 1;
      end
      if (cwr && csel == 3'b011) begin
        l1_wr <= l1_wr + 1;
        mem1[caddr_wr[9:0]] <= cdata_wr;
        last_l1_addr <= caddr_wr;
        last_l1_cyc  <= cyc;
      end
      if (crd) begin
        if (fr_xfer < N0) early_err <= early_err + 1;
        if (!crd_seen) begin
          crd_seen      <= 1'b1;
          first_crd_cyc <= cyc;
        end
        h0 <= h1; h1 <= h2; h2 <= h3; h3 <= caddr_rd;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      pend <= cv_valid && cv_ready;
      if (cv_valid && cv_ready) begin
        pend_addr     <= cv_addr;
        pend_data     <= cv_data;
        fr_xfer       <= fr_xfer + 1;
        last_xfer_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Pooled word p = signed max of the 2x2 window at row 2*(p/32), col 2*(p%32).
  function automatic logic [19:0] pool_ref(input int p);
    int base, v, best;
    int offs [4];
    offs = '{0, 1, 64, 65};
    base = (p / 32) * 128 + (p % 32) * 2;
    best = 0;
    for (int i = 0; i < 4; i++) begin
      v = int'($signed(exp0[base + offs[i]]));
      if (i == 0 || v > best) best = v;
    end
    return 20'(best);
  endfunction

  function automatic logic [19:0] gen_data(input int idx, input bit ramp);
    if (ramp) return 20'(idx);
    case (idx)
      0:           return 20'hFFFFF;
      1:           return 20'h80000;
      64:          return 20'h00000;
      65:          return 20'hFFFF0;
      2, 3, 66, 67: return 20'h80000;
      default:     return 20'($urandom);
    endcase
  endfunction

  task automatic run_l0(input int n, input bit gaps, input bit ramp, input int poke);
    int idx, budget;
    logic [19:0] d;
    idx = 0;
    budget = 0;
    d = gen_data(0, ramp);
    while (idx < n && budget < 20000) begin
      cv_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cv_addr  = 12'(idx);
      cv_data  = d;
      start    = (idx == poke);
      @(negedge clk);
      if (cv_valid && cv_ready) begin
        exp0[idx] = d;
        idx++;
        if (idx < N0) d = gen_data(idx, ramp);
      end
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    chk("l0_accept_count", 32'(idx), 32'(n));
  endtask

  task automatic wait_done(input bit pokes, output bit seen, output int at_cyc);
    seen = 1'b0;
    at_cyc = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      start = pokes && (k == 40 || k == 3000);
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        at_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit gaps, input bit ramp);
    int s_l0, s_l1, s_done, start_cyc, at_cyc, bad0, bad1, fp, lat;
    bit seen;
    s_l0 = l0_wr; s_l1 = l1_wr; s_done = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'(1));
    run_l0(N0, gaps, ramp, ramp ? 2000 : -1);
    // Junk on the conv port and stray starts during pooling must be ignored.
    cv_valid = ramp;
    cv_addr  = 12'h000;
    cv_data  = 20'h12345;
    wait_done(ramp, seen, at_cyc);
    chk({tag, "_done_seen"}, 32'(seen), 32'(1));
    lat = at_cyc - start_cyc;
    if (!gaps) chk({tag, "_latency_in_range"}, 32'(lat >= 10240 && lat <= 10243), 32'(1));
    repeat (4) @(posedge clk);
    #1;
    cv_valid = 1'b0;
    chk({tag, "_l0_writes"}, 32'(l0_wr - s_l0), 32'(N0));
    chk({tag, "_l1_writes"}, 32'(l1_wr - s_l1), 32'(N1));
    chk({tag, "_done_pulses"}, 32'(done_cnt - s_done), 32'(1));
    chk({tag, "_busy_after_done"}, 32'(busy), 32'(0));
    chk({tag, "_pool_start_gap"}, 32'(first_crd_cyc - last_xfer_cyc), 32'(2));
    chk({tag, "_last_rd0"}, 32'(h0), 32'h0FBE);
    chk({tag, "_last_rd1"}, 32'(h1), 32'h0FBF);
    chk({tag, "_last_rd2"}, 32'(h2), 32'h0FFE);
    chk({tag, "_last_rd3"}, 32'(h3), 32'h0FFF);
    chk({tag, "_last_l1_addr"}, 32'(last_l1_addr), 32'h03FF);
    chk({tag, "_done_after_last_wr"}, 32'(done_cyc - last_l1_cyc), 32'(1));
    bad0 = 0; bad1 = 0; fp = -1;
    for (int i = 0; i < N0; i++) if (mem0[i] !== exp0[i]) bad0++;
    for (int p = 0; p < N1; p++) begin
      if (mem1[p] !== pool_ref(p)) begin
        bad1++;
        if (fp < 0) fp = p;
      end
    end
    chk({tag, "_l0_contents_bad"}, 32'(bad0), 32'(0));
    chk({tag, "_l1_model_bad"}, 32'(bad1), 32'(0));
    if (fp >= 0) chk({tag, "_l1_first_bad_word"}, 32'(mem1[fp]), 32'(pool_ref(fp)));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cv_valid = 1'b0; cv_addr = '0; cv_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cv_ready", 32'(cv_ready), 32'(0));
    chk("rst_cwr", 32'(cwr), 32'(0));
    chk("rst_crd", 32'(crd), 32'(0));
    chk("rst_caddr_wr", 32'(caddr_wr), 32'(0));
    chk("rst_caddr_rd", 32'(caddr_rd), 32'(0));
    chk("rst_cdata_wr", 32'(cdata_wr), 32'(0));
    chk("rst_csel", 32'(csel), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Abort a frame after 100 transfers.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_l0(100, 1'b0, 1'b1, -1);
    reset = 1'b1;
    cv_valid = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_cwr", 32'(cwr), 32'(0));
    chk("abort_csel", 32'(csel), 32'(0));
    chk("abort_cv_ready", 32'(cv_ready), 32'(0));
    chk("abort_crd", 32'(crd), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cv_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_cv_ready", 32'(cv_ready), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    cv_valid = 1'b0;

    run_frame("ramp", 1'b0, 1'b1);
    run_frame("rand", 1'b1, 1'b0);
    chk("signed_max_mixed", 32'(mem1[0]), 32'h00000);
    chk("signed_max_all_min", 32'(mem1[1]), 32'h80000);

    chk("l0_write_latency_errs", 32'(lat_err), 32'(0));
    chk("rd_wr_overlap_errs", 32'(excl_err), 32'(0));
    chk("csel_errs", 32'(sel_err), 32'(0));
    chk("idle_strobe_errs", 32'(idle_err), 32'(0));
    chk("ready_in_pool_errs", 32'(rdy_err), 32'(0));
    chk("early_read_errs", 32'(early_err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
